// File: rtl/uart_terminal_writer.sv
// Turns bytes from the UART receiver into character RAM writes for the VGA text buffer.
// Keeps a text cursor, decodes control characters, and blanks rows or the whole screen.
module uart_terminal_writer #(
  parameter int          COLUMNS    = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  localparam int         COL_W      = $clog2(COLUMNS),
  localparam int         ROW_W      = $clog2(ROWS)
) (
  input  logic                  clockIN,
  input  logic                  nResetIN,
  input  logic                  rxReadyIN,
  input  logic [7:0]            rxDataIN,
  output logic                  memWriteEnableOUT,
  output logic [ADDR_WIDTH-1:0] memAddressOUT,
  output logic [7:0]            memDataOUT,
  output logic [COL_W-1:0]      cursorColumnOUT,
  output logic [ROW_W-1:0]      cursorRowOUT,
  output logic                  busyOUT,
  output logic                  overflowOUT,
  output logic [1:0]            stateDebugOUT
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_EXEC         = 2'd1,
    ST_CLEAR_ROW    = 2'd2,
    ST_CLEAR_SCREEN = 2'd3
  } state_e;

  localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_END    = ADDR_WIDTH'(COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] SCREEN_END = ADDR_WIDTH'(COLUMNS * ROWS - 1);

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  hist_q, hist_d;
  logic                  pend_full_q, pend_full_d;
  logic [7:0]            pend_data_q, pend_data_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                  rx_edge;
  logic                  take;
  logic                  overflow;
  logic                  line_feed;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] cursor_addr;

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      pend_full_q <= 1'b0;
      pend_data_q <= 8'h00;
      cmd_q       <= 8'h00;
      col_q       <= '0;
      row_q       <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      cmd_q       <= cmd_d;
      col_q       <= col_d;
      row_q       <= row_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  // Receive side: synchronise the ready level and keep one pending byte.
  // A byte leaving pending in the same cycle frees the slot for a new edge.
  always_comb begin
    sync1_d     = rxReadyIN;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    rx_edge     = sync2_q & ~hist_q;
    take        = (state_q == ST_IDLE) && pend_full_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    overflow    = 1'b0;
    if (take) pend_full_d = 1'b0;
    if (rx_edge) begin
      if (pend_full_q && !take) begin
        overflow = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_data_d = rxDataIN;
      end
    end
  end

  assign row_base    = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(COLUMNS);
  assign cursor_addr = row_base + ADDR_WIDTH'(col_q);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_cnt_d = clr_cnt_q;
    line_feed = 1'b0;
    we        = 1'b0;
    addr      = cursor_addr;
    data      = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_full_q) begin
          state_d = ST_EXEC;
          cmd_d   = pend_data_q;
        end
      end
      ST_EXEC: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
        if (cmd_q >= 8'h20 && cmd_q <= 8'h7E) begin
          we = 1'b1;
          if (col_q == LAST_COL) begin
            col_d     = '0;
            line_feed = 1'b1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          case (cmd_q)
            8'h0D: col_d = '0;
            8'h0A: line_feed = 1'b1;
            8'h08: begin
              if (col_q != '0) begin
                col_d = col_q - COL_W'(1);
                we    = 1'b1;
                addr  = cursor_addr - ADDR_WIDTH'(1);
                data  = BLANK_CHAR;
              end
            end
            8'h0C: begin
              col_d   = '0;
              row_d   = '0;
              state_d = ST_CLEAR_SCREEN;
            end
            default: ;
          endcase
        end
        // The row being entered is always blanked, whether by LF or by wrap.
        if (line_feed) begin
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
          state_d = ST_CLEAR_ROW;
        end
      end
      ST_CLEAR_ROW: begin
        we        = 1'b1;
        addr      = row_base + clr_cnt_q;
        data      = BLANK_CHAR;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ROW_END) state_d = ST_IDLE;
      end
      ST_CLEAR_SCREEN: begin
        we        = 1'b1;
        addr      = clr_cnt_q;
        data      = BLANK_CHAR;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == SCREEN_END) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign memWriteEnableOUT = we;
  assign memAddressOUT     = addr;
  assign memDataOUT        = data;
  assign cursorColumnOUT   = col_q;
  assign cursorRowOUT      = row_q;
  assign busyOUT           = (state_q != ST_IDLE);
  assign overflowOUT       = overflow;
  assign stateDebugOUT     = state_q;

endmodule

// File: tb/tb_uart_terminal_writer.sv
// Randomised bench for uart_terminal_writer: a screen-level model predicts writes,
// cursor, busy time and drops; a monitor checks every write strobe against the queue.
module tb_uart_terminal_writer;

  localparam int C  = 80;
  localparam int R  = 30;
  localparam int AW = 12;

  logic          clk;
  logic          nResetIN;
  logic          rxReadyIN;
  logic [7:0]    rxDataIN;
  logic          memWriteEnableOUT;
  logic [AW-1:0] memAddressOUT;
  logic [7:0]    memDataOUT;
  logic [6:0]    cursorColumnOUT;
  logic [4:0]    cursorRowOUT;
  logic          busyOUT;
  logic          overflowOUT;
  logic [1:0]    stateDebugOUT;

  uart_terminal_writer dut (
    .clockIN           (clk),
    .nResetIN          (nResetIN),
    .rxReadyIN         (rxReadyIN),
    .rxDataIN          (rxDataIN),
    .memWriteEnableOUT (memWriteEnableOUT),
    .memAddressOUT     (memAddressOUT),
    .memDataOUT        (memDataOUT),
    .cursorColumnOUT   (cursorColumnOUT),
    .cursorRowOUT      (cursorRowOUT),
    .busyOUT           (busyOUT),
    .overflowOUT       (overflowOUT),
    .stateDebugOUT     (stateDebugOUT)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [AW+7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int exp_busy = 0;
  int ovf_cnt = 0;
  int exp_ovf = 0;
  int m_col = 0;
  int m_row = 0;

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (nResetIN) begin
      if (busyOUT) busy_cnt++;
      if (overflowOUT) ovf_cnt++;
      if (memWriteEnableOUT) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                   memAddressOUT, memDataOUT);
        end else begin
          logic [AW+7:0] e;
          e = exp_q.pop_front();
          if ({memAddressOUT, memDataOUT} !== e) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                     memAddressOUT, memDataOUT, e[AW+7:8], e[7:0]);
          end
        end
      end
    end
  end

  // reference model, expressed as screen operations
  task automatic push_write(input int a, input logic [7:0] d);
    logic [AW-1:0] aa;
    aa = AW'(a);
    exp_q.push_back({aa, d});
  endtask

  task automatic model_newline();
    m_row = (m_row + 1) % R;
    for (int k = 0; k < C; k++) push_write(m_row * C + k, 8'h20);
    exp_busy += C;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_busy += 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_write(m_row * C + m_col, b);
      m_col++;
      if (m_col == C) begin
        m_col = 0;
        model_newline();
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_write(m_row * C + m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      for (int a = 0; a < C * R; a++) push_write(a, 8'h20);
      exp_busy += C * R;
    end
  endtask

  // driver tasks
  task automatic pulse(input logic [7:0] b, input int hold);
    @(negedge clk);
    rxDataIN  = b;
    rxReadyIN = 1'b1;
    repeat (hold) @(negedge clk);
    rxReadyIN = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic settle_check(input string tag);
    int idle_run;
    int n;
    idle_run = 0;
    n = 0;
    while (idle_run < 6 && n < 5000) begin
      @(negedge clk);
      n++;
      if (busyOUT) idle_run = 0;
      else idle_run++;
    end
    check_int({tag, "_timeout"}, (n >= 5000) ? 1 : 0, 0);
    check_int({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check_int({tag, "_col"}, int'(cursorColumnOUT), m_col);
    check_int({tag, "_row"}, int'(cursorRowOUT), m_row);
    check_int({tag, "_pending_writes"}, exp_q.size(), 0);
    check_int({tag, "_overflows"}, ovf_cnt, exp_ovf);
    busy_cnt = 0;
    exp_busy = 0;
  endtask

  task automatic send(input logic [7:0] b, input int hold, input string tag);
    model_byte(b);
    pulse(b, hold);
    settle_check(tag);
  endtask

  task automatic apply_reset();
    rxReadyIN = 1'b0;
    @(negedge clk);
    nResetIN = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    busy_cnt = 0;
    exp_busy = 0;
    ovf_cnt = 0;
    exp_ovf = 0;
    nResetIN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    nResetIN  = 1'b0;
    rxReadyIN = 1'b0;
    rxDataIN  = 8'h00;
    #12;
    check_int("reset_we", int'(memWriteEnableOUT), 0);
    check_int("reset_addr", int'(memAddressOUT), 0);
    check_int("reset_data", int'(memDataOUT), 0);
    check_int("reset_col", int'(cursorColumnOUT), 0);
    check_int("reset_row", int'(cursorRowOUT), 0);
    check_int("reset_busy", int'(busyOUT), 0);
    check_int("reset_ovf", int'(overflowOUT), 0);
    apply_reset();

    // a long ready level yields exactly one byte
    send(8'h41, 50, "long_level");

    // a full row of printables wraps and blanks the next row
    apply_reset();
    for (int i = 0; i < C; i++) send(8'h58, 2, "row_fill");

    // backspace, carriage return, backspace at column 0
    apply_reset();
    send(8'h0A, 3, "bs_lf");
    send(8'h0A, 3, "bs_lf");
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 3, "bs_fill");
    send(8'h08, 3, "bs_mid");
    send(8'h0D, 3, "cr");
    send(8'h08, 3, "bs_col0");

    // line feed from the last row wraps to row 0
    apply_reset();
    for (int i = 0; i < 3; i++) send(8'h41 + 8'(i), 3, "wrap_text");
    for (int i = 0; i < R; i++) send(8'h0A, 3, "wrap_lf");

    // form feed clears the whole screen
    send(8'h0C, 3, "form_feed");

    // two bytes during a screen clear: the second is dropped
    model_byte(8'h0C);
    pulse(8'h0C, 3);
    model_byte(8'h31);
    pulse(8'h31, 3);
    pulse(8'h32, 3);
    exp_ovf++;
    check_int("ovf_clear_busy", int'(busyOUT), 1);
    settle_check("ovf");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) b = 8'($urandom_range(32, 126));
      else if (kind == 6) b = 8'h0D;
      else if (kind == 7) b = 8'h0A;
      else if (kind == 8) b = 8'h08;
      else begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h0C) b = 8'h0D;
      end
      send(b, $urandom_range(1, 12), "random");
    end

    // reset in the middle of a row clear
    model_byte(8'h0A);
    pulse(8'h0A, 3);
    repeat (5) @(negedge clk);
    check_int("mid_clear_we", int'(memWriteEnableOUT), 1);
    #2;
    nResetIN = 1'b0;
    #1;
    check_int("async_reset_we", int'(memWriteEnableOUT), 0);
    check_int("async_reset_busy", int'(busyOUT), 0);
    check_int("async_reset_col", int'(cursorColumnOUT), 0);
    check_int("async_reset_row", int'(cursorRowOUT), 0);
    apply_reset();
    send(8'h5A, 3, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
